// File: rtl/uart_imem_loader_pkg.sv
// Shared FSM encoding and frame constants for the UART imem loader.
// Checksum byte handling is enabled by UART_IMEM_LOADER_CSUM_EN.
package uart_imem_loader_pkg;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_H  = 3'd1;
  localparam logic [2:0] ST_LEN_L  = 3'd2;
  localparam logic [2:0] ST_DATA_H = 3'd3;
  localparam logic [2:0] ST_DATA_L = 3'd4;
  localparam logic [2:0] ST_CSUM   = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;
  localparam logic [2:0] ST_ERR    = 3'd7;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  function automatic logic is_busy(input state_t s);
    return (s == ST_LEN_H) || (s == ST_LEN_L) ||
           (s == ST_DATA_H) || (s == ST_DATA_L) ||
           (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/uart_imem_loader_timer.sv
// Inter-byte idle timer; term is high on the last allowed idle cycle.
module loader_timeout_timer #(
  parameter logic [23:0] TIMEOUT_CYC = 24'd1_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic clear,
  input  logic enable,
  output logic term
);

  logic [23:0] cnt;

  assign term = enable && (cnt == TIMEOUT_CYC - 24'd1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (clear || !enable) begin
      cnt <= '0;
    end else if (!term) begin
      cnt <= cnt + 24'd1;
    end
  end

endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: UART byte frames into the imem write port, holds CPU reset.
// Define UART_IMEM_LOADER_CSUM_EN to require the trailing checksum byte.
module uart_imem_loader
  import uart_imem_loader_pkg::*;
#(
  parameter int          ADDR_W      = 9,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_DEFAULT,
  parameter logic [23:0] TIMEOUT_CYC = 24'd1_000_000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  output logic              o_mem_we_h,
  output logic              o_mem_we_l,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_din_h,
  output logic [7:0]        o_mem_din_l,
  output logic              o_cpu_rst,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

`ifdef UART_IMEM_LOADER_CSUM_EN
  localparam logic [2:0] ST_END = ST_CSUM;
`else
  localparam logic [2:0] ST_END = ST_DONE;
`endif

  state_t            state;
  state_t            state_d;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       len;
  logic [7:0]        din_q;
  logic              busy;
  logic              tmo;
  logic              sync;
  logic [15:0]       len_n;
  logic              last_word;
  logic              sum_ok;

  assign busy      = is_busy(state);
  assign sync      = (i_rx_data == SYNC_BYTE);
  assign len_n     = {len[15:8], i_rx_data};
  assign last_word = (16'(addr) == len - 16'd1);

  loader_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .clear (i_rx_valid || !busy),
    .enable(busy),
    .term  (tmo)
  );

`ifdef UART_IMEM_LOADER_CSUM_EN
  logic [7:0] sum;

  assign sum_ok = (i_rx_data == sum);

  // Running sum covers both length bytes and every data byte.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sum <= '0;
    end else if (i_rx_valid) begin
      unique case (1'b1)
        (state == ST_IDLE),
        (state == ST_ERR):    if (sync) sum <= '0;
        (state == ST_LEN_H),
        (state == ST_LEN_L),
        (state == ST_DATA_H),
        (state == ST_DATA_L): sum <= sum + i_rx_data;
        default: ;
      endcase
    end
  end
`else
  assign sum_ok = 1'b0;
`endif

  always_comb begin
    state_d = state;
    if (busy && tmo && !i_rx_valid) begin
      state_d = ST_ERR;
    end else if (i_rx_valid) begin
      unique case (1'b1)
        (state == ST_IDLE),
        (state == ST_ERR):    if (sync) state_d = ST_LEN_H;
        (state == ST_LEN_H):  state_d = ST_LEN_L;
        (state == ST_LEN_L): begin
          if ({1'b0, len_n} > MAX_WORDS) state_d = ST_ERR;
          else if (len_n == 16'd0)        state_d = ST_END;
          else                            state_d = ST_DATA_H;
        end
        (state == ST_DATA_H): state_d = ST_DATA_L;
        (state == ST_DATA_L):
          state_d = last_word ? ST_END : ST_DATA_H;
        (state == ST_CSUM):
          state_d = sum_ok ? ST_DONE : ST_ERR;
        (state == ST_DONE):   state_d = ST_DONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      addr       <= '0;
      len        <= '0;
      din_q      <= '0;
      o_mem_we_h <= 1'b0;
      o_mem_we_l <= 1'b0;
      o_mem_addr <= '0;
    end else begin
      state      <= state_d;
      o_mem_we_h <= 1'b0;
      o_mem_we_l <= 1'b0;
      if (i_rx_valid) begin
        unique case (1'b1)
          (state == ST_IDLE),
          (state == ST_ERR):    if (sync) addr <= '0;
          (state == ST_LEN_H):  len[15:8] <= i_rx_data;
          (state == ST_LEN_L):  len[7:0]  <= i_rx_data;
          (state == ST_DATA_H): begin
            o_mem_we_h <= 1'b1;
            o_mem_addr <= addr;
            din_q      <= i_rx_data;
          end
          (state == ST_DATA_L): begin
            o_mem_we_l <= 1'b1;
            o_mem_addr <= addr;
            din_q      <= i_rx_data;
            addr       <= addr + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_mem_din_h = din_q;
  assign o_mem_din_l = din_q;
  assign o_busy      = busy;
  assign o_done      = (state == ST_DONE);
  assign o_cpu_rst   = (state != ST_DONE);
  assign o_err       = (state == ST_ERR);

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed bench for uart_imem_loader (TIMEOUT_CYC=100).
// Works with or without UART_IMEM_LOADER_CSUM_EN defined.
module tb_uart_imem_loader;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_rx_valid = 1'b0;
  logic [7:0] i_rx_data = 8'h00;
  logic       o_mem_we_h, o_mem_we_l;
  logic [8:0] o_mem_addr;
  logic [7:0] o_mem_din_h, o_mem_din_l;
  logic       o_cpu_rst, o_busy, o_done, o_err;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic       h;
    logic       l;
    logic [8:0] a;
    logic [7:0] dh;
    logic [7:0] dl;
  } wr_t;

  wr_t wq[$];

  uart_imem_loader #(
    .ADDR_W     (9),
    .SYNC_BYTE  (8'hA5),
    .TIMEOUT_CYC(24'd100)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rx_valid (i_rx_valid),
    .i_rx_data  (i_rx_data),
    .o_mem_we_h (o_mem_we_h),
    .o_mem_we_l (o_mem_we_l),
    .o_mem_addr (o_mem_addr),
    .o_mem_din_h(o_mem_din_h),
    .o_mem_din_l(o_mem_din_l),
    .o_cpu_rst  (o_cpu_rst),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk)
    if (o_mem_we_h || o_mem_we_l)
      wq.push_back('{h: o_mem_we_h, l: o_mem_we_l, a: o_mem_addr,
                     dh: o_mem_din_h, dl: o_mem_din_l});

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge i_clk);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    @(negedge i_clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic send_csum(input logic [7:0] c);
`ifdef UART_IMEM_LOADER_CSUM_EN
    send_byte(c);
`else
    i_rx_data = c;
`endif
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_rx_valid = 1'b0;
    idle(2);
    i_rst = 1'b0;
    idle(1);
    wq.delete();
  endtask

  task automatic test_reset();
    logic [12:0] got;
    i_rst = 1'b1;
    #1;
    got = {o_cpu_rst, o_busy, o_done, o_err, o_mem_we_h,
           o_mem_we_l, o_mem_addr[6:0]};
    total++;
    if (got !== 13'b1_0000_0000_0000) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want %b", got,
               13'b1_0000_0000_0000);
    end
    total++;
    if ({o_mem_addr, o_mem_din_h, o_mem_din_l} !== 25'd0) begin
      bad++;
      $display("FAIL reset_data: got %h want 0",
               {o_mem_addr, o_mem_din_h, o_mem_din_l});
    end
    do_reset();
  endtask

  task automatic test_good_frame();
    logic [7:0] ed[4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    wr_t e;
    do_reset();
    send_byte(8'hA5);
    total++;
    if (o_busy !== 1'b1) begin
      bad++;
      $display("FAIL good_busy: got %b want 1", o_busy);
    end
    send_byte(8'h00);
    send_byte(8'h02);
    for (int i = 0; i < 4; i++) send_byte(ed[i]);
    send_csum(8'h16);
    idle(2);
    total++;
    if (wq.size() !== 4) begin
      bad++;
      $display("FAIL good_nwr: got %0d want 4", wq.size());
    end
    for (int i = 0; i < 4; i++) begin
      e = '{h: (i % 2 == 0), l: (i % 2 == 1), a: 9'(i / 2),
            dh: ed[i], dl: ed[i]};
      if (wq.size() > i) begin
        total++;
        if (wq[i] !== e) begin
          bad++;
          $display("FAIL good_wr%0d: got %h want %h", i, wq[i], e);
        end
      end
    end
    total++;
    if ({o_done, o_cpu_rst, o_err, o_busy} !== 4'b1000) begin
      bad++;
      $display("FAIL good_status: got %b want 1000",
               {o_done, o_cpu_rst, o_err, o_busy});
    end
  endtask

  task automatic test_err_recovery();
    do_reset();
    send_byte(8'hA5);
`ifdef UART_IMEM_LOADER_CSUM_EN
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    send_byte(8'h17);
    idle(2);
    total++;
    if (wq.size() !== 4) begin
      bad++;
      $display("FAIL badsum_nwr: got %0d want 4", wq.size());
    end
`else
    send_byte(8'h02);
    send_byte(8'h01);
    idle(2);
`endif
    total++;
    if ({o_err, o_cpu_rst, o_done} !== 3'b110) begin
      bad++;
      $display("FAIL err_status: got %b want 110",
               {o_err, o_cpu_rst, o_done});
    end
    send_byte(8'hA5);
    total++;
    if ({o_err, o_busy} !== 2'b01) begin
      bad++;
      $display("FAIL err_clear: got %b want 01", {o_err, o_busy});
    end
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_csum(8'h79);
    idle(2);
    total++;
    if ({o_done, o_err, o_cpu_rst} !== 3'b100) begin
      bad++;
      $display("FAIL recover_status: got %b want 100",
               {o_done, o_err, o_cpu_rst});
    end
  endtask

  task automatic test_overlength();
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h01);
    total++;
    if ({o_err, o_busy, o_cpu_rst} !== 3'b101) begin
      bad++;
      $display("FAIL ovl_status: got %b want 101",
               {o_err, o_busy, o_cpu_rst});
    end
    send_byte(8'h12);
    idle(2);
    total++;
    if (wq.size() !== 0) begin
      bad++;
      $display("FAIL ovl_nwr: got %0d want 0", wq.size());
    end
  endtask

  task automatic test_max_length();
    wr_t e;
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    for (int i = 0; i < 1024; i++) send_byte(8'h01);
    send_csum(8'h02);
    idle(2);
    total++;
    if (wq.size() !== 1024) begin
      bad++;
      $display("FAIL max_nwr: got %0d want 1024", wq.size());
    end
    e = '{h: 1'b0, l: 1'b1, a: 9'd511, dh: 8'h01, dl: 8'h01};
    if (wq.size() == 1024) begin
      total++;
      if (wq[1023] !== e) begin
        bad++;
        $display("FAIL max_last: got %h want %h", wq[1023], e);
      end
    end
    total++;
    if ({o_done, o_err} !== 2'b10) begin
      bad++;
      $display("FAIL max_status: got %b want 10", {o_done, o_err});
    end
  endtask

  task automatic test_timeout();
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h12);
    idle(99);
    total++;
    if ({o_err, o_busy} !== 2'b01) begin
      bad++;
      $display("FAIL tmo_early: got %b want 01", {o_err, o_busy});
    end
    idle(1);
    total++;
    if ({o_err, o_busy, o_cpu_rst} !== 3'b101) begin
      bad++;
      $display("FAIL tmo_fire: got %b want 101",
               {o_err, o_busy, o_cpu_rst});
    end
    total++;
    if (wq.size() !== 1) begin
      bad++;
      $display("FAIL tmo_nwr: got %0d want 1", wq.size());
    end
  endtask

  task automatic test_terminal_byte();
    wr_t e;
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h12);
    idle(98);
    send_byte(8'h34);
    total++;
    if (o_err !== 1'b0) begin
      bad++;
      $display("FAIL term_err: got %b want 0", o_err);
    end
    send_csum(8'h47);
    idle(2);
    e = '{h: 1'b0, l: 1'b1, a: 9'd0, dh: 8'h34, dl: 8'h34};
    total++;
    if (wq.size() !== 2) begin
      bad++;
      $display("FAIL term_nwr: got %0d want 2", wq.size());
    end else begin
      total++;
      if (wq[1] !== e) begin
        bad++;
        $display("FAIL term_wr: got %h want %h", wq[1], e);
      end
    end
    total++;
    if ({o_done, o_err} !== 2'b10) begin
      bad++;
      $display("FAIL term_status: got %b want 10", {o_done, o_err});
    end
  endtask

  task automatic test_garbage();
    do_reset();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h3C);
    idle(1);
    total++;
    if ({o_busy, o_err, o_done, o_cpu_rst} !== 4'b0001) begin
      bad++;
      $display("FAIL garb_status: got %b want 0001",
               {o_busy, o_err, o_done, o_cpu_rst});
    end
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    send_csum(8'h00);
    idle(2);
    total++;
    if ({o_done, o_cpu_rst} !== 2'b10) begin
      bad++;
      $display("FAIL empty_done: got %b want 10", {o_done, o_cpu_rst});
    end
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h12);
    send_byte(8'h34);
    idle(2);
    total++;
    if (wq.size() !== 0) begin
      bad++;
      $display("FAIL post_done_nwr: got %0d want 0", wq.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    wr_t e;
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    total++;
    if (o_mem_we_h !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre_we: got %b want 1", o_mem_we_h);
    end
    i_rst = 1'b1;
    #1;
    total++;
    if ({o_mem_we_h, o_busy, o_cpu_rst, o_mem_din_h} !== 11'h100) begin
      bad++;
      $display("FAIL mid_async: got %h want 100",
               {o_mem_we_h, o_busy, o_cpu_rst, o_mem_din_h});
    end
    idle(1);
    i_rst = 1'b0;
    idle(1);
    wq.delete();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_csum(8'h79);
    idle(2);
    e = '{h: 1'b1, l: 1'b0, a: 9'd0, dh: 8'hAB, dl: 8'hAB};
    total++;
    if (wq.size() !== 2) begin
      bad++;
      $display("FAIL mid_nwr: got %0d want 2", wq.size());
    end else begin
      total++;
      if (wq[0] !== e) begin
        bad++;
        $display("FAIL mid_wr0: got %h want %h", wq[0], e);
      end
    end
    total++;
    if (o_done !== 1'b1) begin
      bad++;
      $display("FAIL mid_done: got %b want 1", o_done);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_err_recovery();
    test_overlength();
    test_max_length();
    test_timeout();
    test_terminal_byte();
    test_garbage();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
